// File: rtl/morse_tx.sv
// -----------------------------------------------------------------------------
// morse_tx -- keys one Morse character (A-Z, 0-9) per request.
//
// A request (start with a valid char_idx) accepted in IDLE loads the character's
// dot/dash pattern from an internal ROM and plays it out element by element:
// MARK (dot = 1 unit, dash = 3 units), GAP (1 unit) between elements, and a
// trailing LGAP (3 units) after the last element. A unit is UNIT_CYCLES clocks.
// During MARK the buzzer output toggles every TONE_HALF clocks, starting high.
//
// Parameters
//   UNIT_CYCLES  clock cycles per Morse unit (2 .. 2^24-1)
//   TONE_HALF    half-period of the tone in clock cycles (1 .. 2^20-1)
//
// Ports
//   clk       system clock, rising edge
//   rst       synchronous active-low reset
//   start     send request, honoured only while idle
//   char_idx  0-25 = A-Z, 26-35 = 0-9, 36-63 invalid
//   busy      high while a character is being keyed
//   done      one-cycle pulse in the first idle cycle after a character
//   err       one-cycle pulse after an invalid request
//   key       high during every mark element
//   beep      audible tone, gated by key
// -----------------------------------------------------------------------------
module morse_tx #(
    parameter int unsigned UNIT_CYCLES = 10_000_000,
    parameter int unsigned TONE_HALF   = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] char_idx,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       key,
    output logic       beep
);

    // Unit counter must reach 3*UNIT_CYCLES-1; tone counter must reach 2*TONE_HALF-1.
    localparam int unsigned CNT_W  = $clog2(3 * UNIT_CYCLES);
    localparam int unsigned TONE_W = $clog2(2 * TONE_HALF);

    localparam logic [CNT_W-1:0]  UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(3 * UNIT_CYCLES - 1);
    localparam logic [TONE_W-1:0] TONE_HI   = TONE_W'(TONE_HALF);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(2 * TONE_HALF - 1);

    localparam logic [5:0] LAST_VALID = 6'd35;

    typedef enum logic [1:0] {
        StIdle,
        StMark,
        StGap,
        StLgap
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  unit_cnt;
    logic [TONE_W-1:0] tone_cnt;
    // Pattern is left-aligned: bit 4 is the element being sent, 1 = dash.
    logic [4:0]        pattern;
    logic [2:0]        remaining;

    logic [7:0]        rom_entry;
    logic [CNT_W-1:0]  mark_last;
    logic [TONE_W-1:0] tone_next;

    // ROM entry: {length[2:0], pattern[4:0]}, pattern MSB-first, dash = 1.
    function automatic logic [7:0] rom_lookup(input logic [5:0] idx);
        logic [7:0] r;
        case (idx)
            6'd0:    r = {3'd2, 5'b01000}; // A .-
            6'd1:    r = {3'd4, 5'b10000}; // B -...
            6'd2:    r = {3'd4, 5'b10100}; // C -.-.
            6'd3:    r = {3'd3, 5'b10000}; // D -..
            6'd4:    r = {3'd1, 5'b00000}; // E .
            6'd5:    r = {3'd4, 5'b00100}; // F ..-.
            6'd6:    r = {3'd3, 5'b11000}; // G --.
            6'd7:    r = {3'd4, 5'b00000}; // H ....
            6'd8:    r = {3'd2, 5'b00000}; // I ..
            6'd9:    r = {3'd4, 5'b01110}; // J .---
            6'd10:   r = {3'd3, 5'b10100}; // K -.-
            6'd11:   r = {3'd4, 5'b01000}; // L .-..
            6'd12:   r = {3'd2, 5'b11000}; // M --
            6'd13:   r = {3'd2, 5'b10000}; // N -.
            6'd14:   r = {3'd3, 5'b11100}; // O ---
            6'd15:   r = {3'd4, 5'b01100}; // P .--.
            6'd16:   r = {3'd4, 5'b11010}; // Q --.-
            6'd17:   r = {3'd3, 5'b01000}; // R .-.
            6'd18:   r = {3'd3, 5'b00000}; // S ...
            6'd19:   r = {3'd1, 5'b10000}; // T -
            6'd20:   r = {3'd3, 5'b00100}; // U ..-
            6'd21:   r = {3'd4, 5'b00010}; // V ...-
            6'd22:   r = {3'd3, 5'b01100}; // W .--
            6'd23:   r = {3'd4, 5'b10010}; // X -..-
            6'd24:   r = {3'd4, 5'b10110}; // Y -.--
            6'd25:   r = {3'd4, 5'b11000}; // Z --..
            6'd26:   r = {3'd5, 5'b11111}; // 0 -----
            6'd27:   r = {3'd5, 5'b01111}; // 1 .----
            6'd28:   r = {3'd5, 5'b00111}; // 2 ..---
            6'd29:   r = {3'd5, 5'b00011}; // 3 ...--
            6'd30:   r = {3'd5, 5'b00001}; // 4 ....-
            6'd31:   r = {3'd5, 5'b00000}; // 5 .....
            6'd32:   r = {3'd5, 5'b10000}; // 6 -....
            6'd33:   r = {3'd5, 5'b11000}; // 7 --...
            6'd34:   r = {3'd5, 5'b11100}; // 8 ---..
            6'd35:   r = {3'd5, 5'b11110}; // 9 ----.
            default: r = 8'd0;
        endcase
        return r;
    endfunction

    always_comb begin
        rom_entry = rom_lookup(char_idx);
        mark_last = pattern[4] ? LONG_LAST : UNIT_LAST;
        tone_next = (tone_cnt == TONE_LAST) ? '0 : tone_cnt + TONE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= StIdle;
            unit_cnt  <= '0;
            tone_cnt  <= '0;
            pattern   <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            key       <= 1'b0;
            beep      <= 1'b0;
        end else begin
            // Pulses default low so each event lasts exactly one cycle.
            done <= 1'b0;
            err  <= 1'b0;

            case (state)
                StIdle: begin
                    if (start) begin
                        if (char_idx <= LAST_VALID) begin
                            state     <= StMark;
                            remaining <= rom_entry[7:5];
                            pattern   <= rom_entry[4:0];
                            unit_cnt  <= '0;
                            tone_cnt  <= '0;
                            busy      <= 1'b1;
                            key       <= 1'b1;
                            beep      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end

                StMark: begin
                    if (unit_cnt == mark_last) begin
                        // Mark over: tone is cut wherever it happens to be.
                        state     <= (remaining == 3'd1) ? StLgap : StGap;
                        pattern   <= {pattern[3:0], 1'b0};
                        remaining <= remaining - 3'd1;
                        unit_cnt  <= '0;
                        tone_cnt  <= '0;
                        key       <= 1'b0;
                        beep      <= 1'b0;
                    end else begin
                        unit_cnt <= unit_cnt + CNT_W'(1);
                        tone_cnt <= tone_next;
                        beep     <= (tone_next < TONE_HI);
                    end
                end

                StGap: begin
                    if (unit_cnt == UNIT_LAST) begin
                        state    <= StMark;
                        unit_cnt <= '0;
                        tone_cnt <= '0;
                        key      <= 1'b1;
                        beep     <= 1'b1;
                    end else begin
                        unit_cnt <= unit_cnt + CNT_W'(1);
                    end
                end

                StLgap: begin
                    if (unit_cnt == LONG_LAST) begin
                        state    <= StIdle;
                        unit_cnt <= '0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end else begin
                        unit_cnt <= unit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state    <= StIdle;
                    unit_cnt <= '0;
                    tone_cnt <= '0;
                    busy     <= 1'b0;
                    key      <= 1'b0;
                    beep     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_morse_tx.sv
// -----------------------------------------------------------------------------
// tb_morse_tx -- scoreboard bench for morse_tx (UNIT_CYCLES=4, TONE_HALF=1).
//
// A reference model watches the inputs at each rising edge and, from the
// textual dot/dash code of the accepted character, predicts the output vector
// {busy,done,err,key,beep} of the following cycle and queues it. A monitor
// pops one prediction per cycle on the falling edge and compares. Directed
// scenarios additionally time the done pulse against fixed cycle numbers.
// -----------------------------------------------------------------------------
module tb_morse_tx;

    localparam int U  = 4;
    localparam int TH = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [5:0] char_idx = 6'd0;
    logic       busy, done, err, key, beep;

    int checks = 0;
    int errors = 0;

    logic [4:0] expq[$];
    logic [4:0] plan[$];

    morse_tx #(
        .UNIT_CYCLES(U),
        .TONE_HALF  (TH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .char_idx(char_idx),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .key     (key),
        .beep    (beep)
    );

    always #5 clk = ~clk;

    function automatic string morse_code(input int i);
        case (i)
            0:  return ".-";    1:  return "-...";  2:  return "-.-.";  3:  return "-..";
            4:  return ".";     5:  return "..-.";  6:  return "--.";   7:  return "....";
            8:  return "..";    9:  return ".---";  10: return "-.-";   11: return ".-..";
            12: return "--";    13: return "-.";    14: return "---";   15: return ".--.";
            16: return "--.-";  17: return ".-.";   18: return "...";   19: return "-";
            20: return "..-";   21: return "...-";  22: return ".--";   23: return "-..-";
            24: return "-.--";  25: return "--..";
            26: return "-----"; 27: return ".----"; 28: return "..---"; 29: return "...--";
            30: return "....-"; 31: return "....."; 32: return "-...."; 33: return "--...";
            34: return "---.."; 35: return "----.";
            default: return "";
        endcase
    endfunction

    function automatic logic [4:0] vec(input bit b, input bit d, input bit e,
                                       input bit k, input bit bp);
        return {b, d, e, k, bp};
    endfunction

    // Expand a character into its full per-cycle output waveform.
    task automatic build_plan(input int idx);
        string c;
        int    d;
        c = morse_code(idx);
        for (int e = 0; e < c.len(); e++) begin
            d = (c.getc(e) == "-") ? 3 * U : U;
            for (int i = 0; i < d; i++)
                plan.push_back(vec(1, 0, 0, 1, (i % (2 * TH)) < TH));
            d = (e == c.len() - 1) ? 3 * U : U;
            for (int i = 0; i < d; i++)
                plan.push_back(vec(1, 0, 0, 0, 0));
        end
        plan.push_back(vec(0, 1, 0, 0, 0));
    endtask

    // Reference model: decides the next cycle's outputs from this edge's inputs.
    initial begin
        logic [4:0] nxt;
        forever begin
            @(posedge clk);
            if (!rst) begin
                plan.delete();
                nxt = '0;
            end else if (plan.size() == 0) begin
                if (start && int'(char_idx) <= 35) begin
                    build_plan(int'(char_idx));
                    nxt = plan.pop_front();
                end else if (start) begin
                    nxt = vec(0, 0, 1, 0, 0);
                end else begin
                    nxt = '0;
                end
            end else begin
                nxt = plan.pop_front();
            end
            expq.push_back(nxt);
        end
    end

    // Monitor: one comparison per cycle, away from the active edge.
    initial begin
        logic [4:0] want;
        logic [4:0] got;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                want = expq.pop_front();
                got  = {busy, done, err, key, beep};
                checks++;
                if (got !== want) begin
                    errors++;
                    $display("FAIL outputs t=%0t busy,done,err,key,beep got %05b required %05b",
                             $time, got, want);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, want);
        end
    endtask

    // Count cycles until done, starting at cycle start_n; optionally jiggle inputs.
    task automatic wait_done(input int start_n, input int want, input string name,
                             input bit noise, output int got);
        int n;
        n = start_n;
        while (!done && n < start_n + 200) begin
            if (noise) begin
                start    = 1'($urandom_range(0, 1));
                char_idx = 6'($urandom_range(0, 63));
            end
            cycle();
            n++;
        end
        if (noise) start = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout waiting for done got none required cycle %0d", name, want);
        end else begin
            check_val(name, n, want);
        end
        got = n;
    endtask

    initial begin
        int n;
        repeat (3) cycle();
        rst = 1'b1;
        repeat (2) cycle();

        // 'A': done in cycle 33.
        start = 1'b1; char_idx = 6'd0; cycle(); start = 1'b0;
        wait_done(1, 33, "done_cycle_A", 1'b0, n);
        repeat (3) cycle();

        // 'E': done in cycle 17.
        start = 1'b1; char_idx = 6'd4; cycle(); start = 1'b0;
        wait_done(1, 17, "done_cycle_E", 1'b0, n);
        repeat (3) cycle();

        // Invalid code: single err pulse, nothing else.
        start = 1'b1; char_idx = 6'd40; cycle(); start = 1'b0;
        check_val("err_pulse_c1", int'(err), 1);
        check_val("busy_on_err", int'(busy), 0);
        cycle();
        check_val("err_pulse_c2", int'(err), 0);
        repeat (3) cycle();

        // 'E' then held start with 'T': T accepted in done cycle, its done in 42.
        start = 1'b1; char_idx = 6'd4; cycle(); char_idx = 6'd19;
        wait_done(1, 17, "done_cycle_E_held", 1'b0, n);
        cycle();
        wait_done(n + 1, 42, "done_cycle_T_b2b", 1'b0, n);
        start = 1'b0;
        repeat (3) cycle();

        // '0' aborted by reset in cycle 10, then a clean 'E'.
        start = 1'b1; char_idx = 6'd26; cycle(); start = 1'b0;
        repeat (9) cycle();
        rst = 1'b0; start = 1'b1; cycle();
        check_val("outputs_after_reset", int'({busy, done, err, key, beep}), 0);
        rst = 1'b1; start = 1'b0;
        repeat (2) cycle();
        start = 1'b1; char_idx = 6'd4; cycle(); start = 1'b0;
        wait_done(1, 17, "done_cycle_E_after_reset", 1'b0, n);
        repeat (3) cycle();

        // 'A' with inputs toggling while busy: timing unchanged.
        start = 1'b1; char_idx = 6'd0; cycle(); start = 1'b0;
        wait_done(1, 33, "done_cycle_A_noisy", 1'b1, n);
        repeat (3) cycle();

        // Random traffic, including invalid codes and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            rst      = ($urandom_range(0, 299) != 0);
            start    = ($urandom_range(0, 3) == 0);
            char_idx = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(36, 63))
                                                   : 6'($urandom_range(0, 35));
            cycle();
        end
        rst = 1'b1;
        start = 1'b0;
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 Parameter UNIT_CYCLES, default 10_000_000, clock cycles per Morse time unit (dot length); legal range 2 to 2^24-1.
REQ-002 Parameter TONE_HALF, default 500_000, half-period of the audible tone in clock cycles; legal range 1 to 2^20-1.
REQ-003 clk  input  1  single system clock; all logic on the rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-005 start  input  1  request to send one character; sampled only in IDLE.
REQ-006 char_idx  input  6  character code: 0-25 = A-Z, 26-35 = digits 0-9, 36-63 invalid.
REQ-007 busy  output  1  high while a character is being keyed.
REQ-008 done  output  1  one-cycle pulse on completion of a character.
REQ-009 err  output  1  one-cycle pulse on rejection of an invalid char_idx.
REQ-010 key  output  1  high during every mark (dot or dash) element.
REQ-011 beep  output  1  audible tone, active high; drives the buzzer pin.

Function
REQ-012 Internal ROM SHALL map each valid char_idx to a length (1-5) and a dot/dash pattern per ITU Morse, sent MSB-first (e.g. A = .-, 0 = -----).
REQ-013 States SHALL be: IDLE, MARK, GAP, LGAP.
REQ-014 IDLE: start=1 with char_idx<=35 -> load pattern, enter MARK next cycle; busy=1 and key=1 from that cycle.
REQ-015 IDLE: start=1 with char_idx>=36 -> err=1 for exactly the next cycle; remain in IDLE; busy stays 0.
REQ-016 MARK SHALL last exactly UNIT_CYCLES cycles for a dot, 3*UNIT_CYCLES for a dash; key=1 throughout.
REQ-017 MARK end with elements remaining -> GAP for exactly UNIT_CYCLES cycles, key=0, then MARK for the next element.
REQ-018 MARK end on the last element -> LGAP for exactly 3*UNIT_CYCLES cycles, key=0 (no intervening GAP).
REQ-019 LGAP end -> IDLE; in the first IDLE cycle done=1, busy=0.
REQ-020 start SHALL be ignored while busy=1; start asserted in the done cycle SHALL be accepted as a new request.
REQ-021 The unit counter SHALL be wide enough for 3*UNIT_CYCLES-1 without wrap; it clears on every state change.
REQ-022 beep SHALL be 0 whenever key=0.
REQ-023 During MARK, beep SHALL be 1 for TONE_HALF cycles then 0 for TONE_HALF cycles, repeating; the phase restarts with beep=1 at the first cycle of each MARK.
REQ-024 The tone counter SHALL wrap from 2*TONE_HALF-1 to 0 without glitch; a MARK ending mid-period truncates the tone.
REQ-025 done and err SHALL never be high in the same cycle, and neither SHALL be high for more than one cycle per event.
REQ-026 char_idx SHALL be sampled only at acceptance; changes during busy SHALL have no effect.

Reset
REQ-027 rst=0 at a rising edge -> next cycle: state IDLE, busy=0, done=0, err=0, key=0, beep=0, all counters 0.
REQ-028 Reset mid-character SHALL abort it with no done pulse; the first start after rst returns to 1 SHALL be honoured normally.
REQ-029 start asserted while rst=0 SHALL be ignored.

Verification (UNIT_CYCLES=4, TONE_HALF=1; start pulsed in cycle 0)
REQ-030 char_idx=0 ('A') -> key=1 cycles 1-4, 0 cycles 5-8, 1 cycles 9-20, 0 cycles 21-32; busy=1 cycles 1-32; done=1 in cycle 33 only.
REQ-031 char_idx=4 ('E') -> key=1 cycles 1-4; beep=1,0,1,0 in cycles 1-4; key=0 cycles 5-16; done in cycle 17.
REQ-032 char_idx=40 -> err=1 in cycle 1 only; busy, key, and beep stay 0; done never asserted.
REQ-033 Send 'E'; hold start=1 continuously with char_idx=19 ('T') -> 'T' accepted in done cycle 17; key=1 cycles 18-29; done in cycle 42.
REQ-034 Send char_idx=26 ('0'), assert rst=0 in cycle 10 -> cycle 11 all outputs 0; no done follows; a new 'E' request after release completes with correct timing.
REQ-035 Toggle char_idx and start during busy of 'A' -> waveform identical to REQ-030.
